// File: rtl/nes_joypad_port_pkg.sv
// ---------------------------------------------------------------------------
// nes_input_pkg
//   Shared definitions for the NES joypad port emulation:
//   - btn_e        : button bit index in the serial report (bit 0 shifts out first)
//   - HID_*        : USB HID usage codes that map onto NES buttons
//   - JOYPAD*_ADDR : CPU addresses of the two controller ports
//   - OPEN_BUS     : fixed value of the undriven upper data bits on a read
//   - key_mask()   : one HID usage code -> one-hot button mask (0 if unmapped)
// ---------------------------------------------------------------------------
package nes_input_pkg;

    typedef enum logic [2:0] {
        BTN_A      = 3'd0,
        BTN_B      = 3'd1,
        BTN_SELECT = 3'd2,
        BTN_START  = 3'd3,
        BTN_UP     = 3'd4,
        BTN_DOWN   = 3'd5,
        BTN_LEFT   = 3'd6,
        BTN_RIGHT  = 3'd7
    } btn_e;

    localparam logic [7:0] HID_NONE  = 8'h00;
    localparam logic [7:0] HID_J     = 8'h0D;  // A
    localparam logic [7:0] HID_K     = 8'h0E;  // B
    localparam logic [7:0] HID_SPACE = 8'h2C;  // Select
    localparam logic [7:0] HID_ENTER = 8'h28;  // Start
    localparam logic [7:0] HID_W     = 8'h1A;  // Up
    localparam logic [7:0] HID_S     = 8'h16;  // Down
    localparam logic [7:0] HID_A     = 8'h04;  // Left
    localparam logic [7:0] HID_D     = 8'h07;  // Right
    localparam logic [7:0] HID_U     = 8'h18;  // turbo A (turbo builds only)
    localparam logic [7:0] HID_I     = 8'h0C;  // turbo B (turbo builds only)

    localparam logic [15:0] JOYPAD1_ADDR = 16'h4016;
    localparam logic [15:0] JOYPAD2_ADDR = 16'h4017;
    localparam logic [7:0]  OPEN_BUS     = 8'h40;

    function automatic logic [7:0] key_mask(input logic [7:0] code);
        logic [7:0] mask;
        mask = 8'h00;
        case (code)
            HID_J:     mask[BTN_A]      = 1'b1;
            HID_K:     mask[BTN_B]      = 1'b1;
            HID_SPACE: mask[BTN_SELECT] = 1'b1;
            HID_ENTER: mask[BTN_START]  = 1'b1;
            HID_W:     mask[BTN_UP]     = 1'b1;
            HID_S:     mask[BTN_DOWN]   = 1'b1;
            HID_A:     mask[BTN_LEFT]   = 1'b1;
            HID_D:     mask[BTN_RIGHT]  = 1'b1;
            default:   mask = 8'h00;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/nes_joypad_port_if.sv
// ---------------------------------------------------------------------------
// nes_joypad_port_if
//   CPU bus slice seen by the joypad port.
//   cpu_access : 1-cycle pulse, one CPU bus cycle is valid this clock
//   cpu_addr   : CPU address
//   cpu_rw_n   : 1 = read, 0 = write
//   cpu_din    : CPU write data
//   cpu_dout   : read data, valid in the same cycle as cpu_access
//   cpu_sel    : address decodes to $4016 or $4017 (combinational)
//   master = CPU / bus decoder side, slave = joypad port side.
// ---------------------------------------------------------------------------
interface nes_joypad_port_if;
    logic        cpu_access;
    logic [15:0] cpu_addr;
    logic        cpu_rw_n;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_sel;

    modport master (
        output cpu_access, cpu_addr, cpu_rw_n, cpu_din,
        input  cpu_dout, cpu_sel
    );

    modport slave (
        input  cpu_access, cpu_addr, cpu_rw_n, cpu_din,
        output cpu_dout, cpu_sel
    );
endinterface

// File: rtl/nes_joypad_port_keymap.sv
// ---------------------------------------------------------------------------
// joypad_keymap
//   Combinational decode of NUM_KEYS HID usage codes into the 8 NES buttons.
//   Any slot may carry any key. Opposing directions pressed together
//   (Up+Down, Left+Right) cancel, as a real pad cannot report both.
//   Ports:
//     keycodes    in  8*NUM_KEYS  slot k = [8k+7:8k], 0x00 = no key
//     turbo_phase in  1           only with NES_JOYPAD_TURBO_EN defined
//     buttons     out 8           bit order A,B,Select,Start,Up,Down,Left,Right
//   Macro: NES_JOYPAD_TURBO_EN adds U (turbo A) and I (turbo B).
// ---------------------------------------------------------------------------
module joypad_keymap
    import nes_input_pkg::*;
#(
    parameter int NUM_KEYS = 1
) (
    input  logic [8*NUM_KEYS-1:0] keycodes,
`ifdef NES_JOYPAD_TURBO_EN
    input  logic                  turbo_phase,
`endif
    output logic [7:0]            buttons
);

    logic [7:0] raw;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        raw     = 8'h00;
        buttons = 8'h00;
        for (int k = 0; k < NUM_KEYS; k++) begin
            raw = raw | key_mask(keycodes[8*k +: 8]);
`ifdef NES_JOYPAD_TURBO_EN
            // A held turbo key pulses its button with the shared turbo phase.
            if (keycodes[8*k +: 8] == HID_U) raw[BTN_A] = raw[BTN_A] | turbo_phase;
            if (keycodes[8*k +: 8] == HID_I) raw[BTN_B] = raw[BTN_B] | turbo_phase;
`endif
        end

        buttons = raw;
        if (raw[BTN_UP] && raw[BTN_DOWN]) begin
            buttons[BTN_UP]   = 1'b0;
            buttons[BTN_DOWN] = 1'b0;
        end
        if (raw[BTN_LEFT] && raw[BTN_RIGHT]) begin
            buttons[BTN_LEFT]  = 1'b0;
            buttons[BTN_RIGHT] = 1'b0;
        end
    end

endmodule

// File: rtl/nes_joypad_port.sv
// ---------------------------------------------------------------------------
// nes_joypad_port
//   NES controller port registers ($4016/$4017) on the CPU bus, fed from the
//   SoC keyboard keycode export.
//   Ports:
//     Clk         in  1           system clock (CPU bus domain)
//     Reset       in  1           synchronous, active-high
//     keycodes    in  8*NUM_KEYS  HID usage codes from the keycode PIO
//     bus         slave           CPU bus (access/addr/rw_n/din -> dout/sel)
//     buttons_dbg out 8           decoded button vector after the sync stages
//   Parameters: NUM_KEYS (1..6), TURBO_DIV (clocks per turbo half-period).
//   Macro: NES_JOYPAD_TURBO_EN enables the turbo counter and U/I keys; when
//   undefined no counter logic exists and TURBO_DIV is ignored.
//   Read $4016 returns {0x40 open bus, serial bit}; $4017 reads 0x40
//   (port 2 unconnected); $4017 writes belong to the APU and are ignored.
// ---------------------------------------------------------------------------
module nes_joypad_port
    import nes_input_pkg::*;
#(
    parameter int          NUM_KEYS  = 1,
    parameter int unsigned TURBO_DIV = 357954
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [8*NUM_KEYS-1:0] keycodes,
    nes_joypad_port_if.slave      bus,
    output logic [7:0]            buttons_dbg
);

    logic [8*NUM_KEYS-1:0] key_sync1;
    logic [8*NUM_KEYS-1:0] key_sync2;
    logic [7:0]            buttons;
    logic [7:0]            shift_reg;
    logic                  strobe;
    logic                  hit_port1;
    logic                  hit_port2;
    logic                  rd_port1;
    logic                  wr_port1;
    logic [6:0]            unused_din;

    assign hit_port1 = (bus.cpu_addr == JOYPAD1_ADDR);
    assign hit_port2 = (bus.cpu_addr == JOYPAD2_ADDR);
    assign rd_port1  = bus.cpu_access &  bus.cpu_rw_n & hit_port1;
    assign wr_port1  = bus.cpu_access & ~bus.cpu_rw_n & hit_port1;

    assign bus.cpu_sel = hit_port1 | hit_port2;
    // Only bit 0 of a $4016 write drives the strobe line.
    assign unused_din  = bus.cpu_din[7:1];

`ifdef NES_JOYPAD_TURBO_EN
    localparam int unsigned TURBO_W = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

    logic [TURBO_W-1:0] turbo_cnt;
    logic               turbo_phase;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            turbo_cnt   <= '0;
            turbo_phase <= 1'b0;
        end else if (turbo_cnt == TURBO_W'(TURBO_DIV - 1)) begin
            turbo_cnt   <= '0;
            turbo_phase <= ~turbo_phase;
        end else begin
            turbo_cnt   <= turbo_cnt + TURBO_W'(1);
        end
    end
`else
    logic unused_turbo_div;
    assign unused_turbo_div = (TURBO_DIV == 0);
`endif

    // Decode from the second sync stage so buttons see a settled keycode.
    joypad_keymap #(
        .NUM_KEYS (NUM_KEYS)
    ) u_keymap (
        .keycodes    (key_sync2),
`ifdef NES_JOYPAD_TURBO_EN
        .turbo_phase (turbo_phase),
`endif
        .buttons     (buttons)
    );

    assign buttons_dbg = buttons;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_sync1 <= '0;
            key_sync2 <= '0;
            strobe    <= 1'b0;
            shift_reg <= 8'hFF;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            key_sync1 <= keycodes;
            key_sync2 <= key_sync1;

            if (wr_port1) strobe <= bus.cpu_din[0];

            // While strobe is high the register tracks the pad continuously;
            // the reload on the clock that drops strobe is the latched report.
            // Shifting fills from the top with 1s, so reads past the eighth
            // return 1 like an official controller.
            if (strobe) begin
                shift_reg <= buttons;
            end else if (rd_port1) begin
                shift_reg <= {1'b1, shift_reg[7:1]};
            end
        end
    end

    always_comb begin
        bus.cpu_dout = 8'h00;
        if (!Reset && bus.cpu_access && bus.cpu_rw_n) begin
            if (hit_port1) begin
                // With strobe high the pad reports live A, i.e. the value this
                // clock's reload is about to capture.
                bus.cpu_dout = {OPEN_BUS[7:1], strobe ? buttons[BTN_A] : shift_reg[0]};
            end else if (hit_port2) begin
                bus.cpu_dout = OPEN_BUS;
            end
        end
    end

endmodule

// File: tb/tb_nes_joypad_port.sv
// ---------------------------------------------------------------------------
// tb_nes_joypad_port
//   Self-checking bench for nes_joypad_port (NUM_KEYS=2, TURBO_DIV=4).
//   Read results go through a scoreboard queue: the expected byte is pushed
//   when the read is driven and popped when the DUT's data is sampled.
//   The turbo scenario runs only when NES_JOYPAD_TURBO_EN is defined.
// ---------------------------------------------------------------------------
module tb_nes_joypad_port;
    import nes_input_pkg::*;

    logic        Clk;
    logic        Reset;
    logic [15:0] keycodes;
    logic [7:0]  buttons_dbg;

    int          checks;
    int          errors;
    logic [7:0]  exp_q[$];

    nes_joypad_port_if bus ();

    nes_joypad_port #(
        .NUM_KEYS  (2),
        .TURBO_DIV (4)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .keycodes    (keycodes),
        .bus         (bus),
        .buttons_dbg (buttons_dbg)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- bus drivers ----------------
    task automatic bus_read(input logic [15:0] addr, output logic [7:0] data);
        @(negedge Clk);
        bus.cpu_access = 1'b1;
        bus.cpu_rw_n   = 1'b1;
        bus.cpu_addr   = addr;
        bus.cpu_din    = 8'h00;
        #1 data = bus.cpu_dout;
        @(posedge Clk);
        #1 bus.cpu_access = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        @(negedge Clk);
        bus.cpu_access = 1'b1;
        bus.cpu_rw_n   = 1'b0;
        bus.cpu_addr   = addr;
        bus.cpu_din    = data;
        @(posedge Clk);
        #1 bus.cpu_access = 1'b0;
        bus.cpu_rw_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic set_keys(input logic [15:0] k);
        @(negedge Clk);
        keycodes = k;
    endtask

    // Drive a read of addr, expecting exp; compare through the scoreboard.
    task automatic sb_read(input string name, input logic [15:0] addr, input logic [7:0] exp);
        logic [7:0] got;
        logic [7:0] want;
        exp_q.push_back(exp);
        bus_read(addr, got);
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] got;
        Reset = 1'b1;
        keycodes = 16'h0000;
        bus.cpu_access = 1'b0;
        bus.cpu_rw_n = 1'b1;
        bus.cpu_addr = 16'h0000;
        bus.cpu_din = 8'h00;
        idle(3);
        checks++;
        if (buttons_dbg !== 8'h00) begin
            errors++;
            $display("FAIL reset_buttons: got %h expected 00", buttons_dbg);
        end
        checks++;
        if (bus.cpu_dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout: got %h expected 00", bus.cpu_dout);
        end
        checks++;
        if (bus.cpu_sel !== 1'b0) begin
            errors++;
            $display("FAIL reset_sel: got %b expected 0", bus.cpu_sel);
        end
        @(negedge Clk);
        Reset = 1'b0;
        // shift_reg resets to FF and strobe to 0: first read gives 0x41.
        exp_q.push_back(8'h41);
        bus_read(JOYPAD1_ADDR, got);
        checks++;
        if (got !== exp_q[0]) begin
            errors++;
            $display("FAIL reset_first_read: got %h expected %h", got, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_keymap();
        logic [7:0] codes [8];
        logic [15:0] k;
        codes = '{HID_J, HID_K, HID_SPACE, HID_ENTER, HID_W, HID_S, HID_A, HID_D};
        for (int i = 0; i < 8; i++) begin
            // Alternate slots so both keycode positions are decoded.
            k = (i % 2 == 1) ? {codes[i], 8'h00} : {8'h00, codes[i]};
            set_keys(k);
            idle(1);
            checks++;
            if (buttons_dbg !== 8'h00) begin
                errors++;
                $display("FAIL keymap_latency1_%0d: got %h expected 00", i, buttons_dbg);
            end
            idle(1);
            checks++;
            if (buttons_dbg !== (8'h01 << i)) begin
                errors++;
                $display("FAIL keymap_key%0d: got %h expected %h", i, buttons_dbg, 8'h01 << i);
            end
            set_keys(16'h0000);
            idle(2);
        end
`ifndef NES_JOYPAD_TURBO_EN
        set_keys({HID_I, HID_U});
        idle(2);
        checks++;
        if (buttons_dbg !== 8'h00) begin
            errors++;
            $display("FAIL keymap_turbo_unmapped: got %h expected 00", buttons_dbg);
        end
        set_keys(16'h0000);
        idle(2);
`endif
    endtask

    task automatic test_serial_a();
        logic [7:0] seq [9];
        seq = '{8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41};
        set_keys({8'h00, HID_J});
        idle(3);
        // Upper data bits are ignored: 0xFF sets strobe, 0xFE clears it.
        bus_write(JOYPAD1_ADDR, 8'hFF);
        bus_write(JOYPAD1_ADDR, 8'hFE);
        for (int i = 0; i < 9; i++) begin
            sb_read($sformatf("serial_a_read%0d", i), JOYPAD1_ADDR, seq[i]);
        end
    endtask

    task automatic test_two_keys();
        logic [7:0] bits;
        bits = 8'b1000_1000;  // Start (bit 3) and Right (bit 7)
        set_keys({HID_ENTER, HID_D});
        idle(3);
        bus_write(JOYPAD1_ADDR, 8'h01);
        bus_write(JOYPAD1_ADDR, 8'h00);
        for (int i = 0; i < 8; i++) begin
            sb_read($sformatf("two_keys_read%0d", i), JOYPAD1_ADDR, {7'b0100000, bits[i]});
        end
    endtask

    task automatic test_strobe_held();
        set_keys({8'h00, HID_K});
        idle(3);
        bus_write(JOYPAD1_ADDR, 8'h01);
        for (int i = 0; i < 3; i++) begin
            sb_read($sformatf("strobe_held_read%0d", i), JOYPAD1_ADDR, 8'h40);
        end
        set_keys({8'h00, HID_J});
        idle(2);
        sb_read("strobe_held_live_a", JOYPAD1_ADDR, 8'h41);
        sb_read("strobe_held_no_shift", JOYPAD1_ADDR, 8'h41);
        bus_write(JOYPAD1_ADDR, 8'h00);
    endtask

    task automatic test_opposing_and_port2();
        set_keys({HID_W, HID_S});
        idle(2);
        checks++;
        if (buttons_dbg !== 8'h00) begin
            errors++;
            $display("FAIL cancel_up_down: got %h expected 00", buttons_dbg);
        end
        set_keys({HID_A, HID_D});
        idle(2);
        checks++;
        if (buttons_dbg !== 8'h00) begin
            errors++;
            $display("FAIL cancel_left_right: got %h expected 00", buttons_dbg);
        end
        set_keys({HID_W, HID_A});
        idle(2);
        checks++;
        if (buttons_dbg !== 8'h50) begin
            errors++;
            $display("FAIL up_left: got %h expected 50", buttons_dbg);
        end

        @(negedge Clk);
        bus.cpu_addr = JOYPAD2_ADDR;
        #1;
        checks++;
        if (bus.cpu_sel !== 1'b1) begin
            errors++;
            $display("FAIL sel_4017: got %b expected 1", bus.cpu_sel);
        end
        @(negedge Clk);
        bus.cpu_addr = 16'h4015;
        #1;
        checks++;
        if (bus.cpu_sel !== 1'b0) begin
            errors++;
            $display("FAIL sel_4015: got %b expected 0", bus.cpu_sel);
        end

        sb_read("port2_read", JOYPAD2_ADDR, 8'h40);
        sb_read("unselected_read", 16'h4015, 8'h00);

        // Latch A only, then a $4017 write with bit 0 set must not raise strobe.
        set_keys({8'h00, HID_J});
        idle(3);
        bus_write(JOYPAD1_ADDR, 8'h01);
        bus_write(JOYPAD1_ADDR, 8'h00);
        bus_write(JOYPAD2_ADDR, 8'h01);
        sb_read("port2_write_read0", JOYPAD1_ADDR, 8'h41);
        sb_read("port2_write_read1", JOYPAD1_ADDR, 8'h40);
    endtask

    task automatic test_mid_reset();
        set_keys({8'h00, HID_K});
        idle(3);
        bus_write(JOYPAD1_ADDR, 8'h01);
        bus_write(JOYPAD1_ADDR, 8'h00);
        sb_read("mid_reset_read0", JOYPAD1_ADDR, 8'h40);
        sb_read("mid_reset_read1", JOYPAD1_ADDR, 8'h41);
        sb_read("mid_reset_read2", JOYPAD1_ADDR, 8'h40);
        @(negedge Clk);
        Reset = 1'b1;
        idle(1);
        checks++;
        if (buttons_dbg !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_buttons: got %h expected 00", buttons_dbg);
        end
        @(negedge Clk);
        Reset = 1'b0;
        sb_read("mid_reset_after0", JOYPAD1_ADDR, 8'h41);
        sb_read("mid_reset_after1", JOYPAD1_ADDR, 8'h41);
        set_keys(16'h0000);
        idle(2);
    endtask

`ifdef NES_JOYPAD_TURBO_EN
    task automatic test_turbo();
        // Edge E0 is the reset edge; counter and phase restart there, so after
        // edge Ek the phase is (k/4) mod 2. Each bus task consumes one edge.
        @(negedge Clk);
        Reset = 1'b1;
        keycodes = {8'h00, HID_U};
        @(posedge Clk);
        #1 Reset = 1'b0;
        bus_write(JOYPAD1_ADDR, 8'h01);  // strobe high from E1
        for (int k = 1; k <= 16; k++) begin
            sb_read($sformatf("turbo_read_k%0d", k), JOYPAD1_ADDR,
                    {7'b0100000, 1'((k >> 2) & 1)});
        end
        bus_write(JOYPAD1_ADDR, 8'h00);
        set_keys(16'h0000);
        idle(2);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_keymap();
        test_serial_a();
        test_two_keys();
        test_strobe_held();
        test_opposing_and_port2();
        test_mid_reset();
`ifdef NES_JOYPAD_TURBO_EN
        test_turbo();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
